// File: rtl/multicycle_controller_pkg.sv
// Shared opcodes, state codes and control-word encodings for the multicycle controller.
// MULTICYCLE_CONTROLLER_TRAP_EN adds the TRAP state and the illegal-instruction flag.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
`else
        S_LUI      = 4'd11
`endif
    } state_e;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       address_select;
        logic       memory_write;
        logic       instruction_write;
        logic       reg_write;
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
        logic       illegal;
`endif
        logic [1:0] result_select;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_controller_output_decoder.sv
// Pure state-to-control-word decode; input-dependent qualification is applied in the top.
import multicycle_controller_pkg::*;

module controller_output_decoder #(
    parameter int STATE_WIDTH = 4
) (
    input  logic [STATE_WIDTH-1:0] state,
    output ctrl_word_t             cw
);

    always_comb begin
        cw = '0;
        case (state)
            STATE_WIDTH'(S_FETCH): begin
                cw.pc_update         = 1'b1;
                cw.instruction_write = 1'b1;
                cw.src_a             = SRCA_PC;
                cw.src_b             = SRCB_FOUR;
                cw.alu_op            = ALU_ADD;
                cw.result_select     = RES_ALURES;
            end
            STATE_WIDTH'(S_DECODE): begin
                cw.src_a = SRCA_OLDPC;
                cw.src_b = SRCB_IMM;
            end
            STATE_WIDTH'(S_MEMADR): begin
                cw.src_a = SRCA_RD1;
                cw.src_b = SRCB_IMM;
            end
            STATE_WIDTH'(S_MEMREAD): begin
                cw.address_select = 1'b1;
                cw.result_select  = RES_ALUOUT;
            end
            STATE_WIDTH'(S_MEMWB): begin
                cw.result_select = RES_RDATA;
                cw.reg_write     = 1'b1;
            end
            STATE_WIDTH'(S_MEMWRITE): begin
                cw.address_select = 1'b1;
                cw.memory_write   = 1'b1;
                cw.result_select  = RES_ALUOUT;
            end
            STATE_WIDTH'(S_EXECR): begin
                cw.src_a  = SRCA_RD1;
                cw.src_b  = SRCB_RD2;
                cw.alu_op = ALU_FUNCT;
            end
            STATE_WIDTH'(S_EXECI): begin
                cw.src_a  = SRCA_RD1;
                cw.src_b  = SRCB_IMM;
                cw.alu_op = ALU_FUNCT;
            end
            STATE_WIDTH'(S_ALUWB): begin
                cw.result_select = RES_ALUOUT;
                cw.reg_write     = 1'b1;
            end
            STATE_WIDTH'(S_BEQ): begin
                cw.src_a         = SRCA_RD1;
                cw.src_b         = SRCB_RD2;
                cw.alu_op        = ALU_SUB;
                cw.result_select = RES_ALUOUT;
                cw.branch        = 1'b1;
            end
            STATE_WIDTH'(S_JAL): begin
                cw.src_a         = SRCA_OLDPC;
                cw.src_b         = SRCB_FOUR;
                cw.alu_op        = ALU_ADD;
                cw.result_select = RES_ALUOUT;
                cw.pc_update     = 1'b1;
            end
            STATE_WIDTH'(S_LUI): begin
                cw.src_a = SRCA_ZERO;
                cw.src_b = SRCB_IMM;
            end
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
            STATE_WIDTH'(S_TRAP): cw.illegal = 1'b1;
`endif
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM; MULTICYCLE_CONTROLLER_TRAP_EN traps undefined opcodes.
import multicycle_controller_pkg::*;

module multicycle_controller #(
    parameter int STATE_WIDTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       memory_ready,
    output logic       pc_write,
    output logic       address_select,
    output logic       memory_write,
    output logic       instruction_write,
    output logic       reg_write,
    output logic [1:0] result_select,
    output logic [1:0] ALU_src_a,
    output logic [1:0] ALU_src_b,
    output logic [1:0] ALU_op,
    output logic       illegal_instruction
);

    logic [STATE_WIDTH-1:0] state_q, state_d;
    ctrl_word_t             cw;
    logic                   fetch_qual;

    always_ff @(posedge clock) begin
        if (reset) state_q <= STATE_WIDTH'(S_FETCH);
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = STATE_WIDTH'(S_FETCH);
        case (state_q)
            STATE_WIDTH'(S_FETCH):
                state_d = memory_ready ? STATE_WIDTH'(S_DECODE) : STATE_WIDTH'(S_FETCH);
            STATE_WIDTH'(S_DECODE): begin
                case (opcode)
                    OP_LW, OP_SW: state_d = STATE_WIDTH'(S_MEMADR);
                    OP_R:         state_d = STATE_WIDTH'(S_EXECR);
                    OP_IALU:      state_d = STATE_WIDTH'(S_EXECI);
                    OP_BEQ:       state_d = STATE_WIDTH'(S_BEQ);
                    OP_JAL:       state_d = STATE_WIDTH'(S_JAL);
                    OP_LUI:       state_d = STATE_WIDTH'(S_LUI);
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
                    default:      state_d = STATE_WIDTH'(S_TRAP);
`else
                    default:      state_d = STATE_WIDTH'(S_FETCH);
`endif
                endcase
            end
            STATE_WIDTH'(S_MEMADR): begin
                case (opcode)
                    OP_LW:   state_d = STATE_WIDTH'(S_MEMREAD);
                    OP_SW:   state_d = STATE_WIDTH'(S_MEMWRITE);
                    default: state_d = STATE_WIDTH'(S_FETCH);
                endcase
            end
            STATE_WIDTH'(S_MEMREAD):
                state_d = memory_ready ? STATE_WIDTH'(S_MEMWB) : STATE_WIDTH'(S_MEMREAD);
            STATE_WIDTH'(S_MEMWRITE):
                state_d = memory_ready ? STATE_WIDTH'(S_FETCH) : STATE_WIDTH'(S_MEMWRITE);
            STATE_WIDTH'(S_EXECR), STATE_WIDTH'(S_EXECI),
            STATE_WIDTH'(S_JAL),   STATE_WIDTH'(S_LUI):
                state_d = STATE_WIDTH'(S_ALUWB);
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
            STATE_WIDTH'(S_TRAP):
                state_d = STATE_WIDTH'(S_TRAP);
`endif
            // MEMWB, ALUWB, BEQ and any unreachable code return to FETCH
            default:
                state_d = STATE_WIDTH'(S_FETCH);
        endcase
    end

    controller_output_decoder #(.STATE_WIDTH(STATE_WIDTH)) u_decoder (
        .state (state_q),
        .cw    (cw)
    );

    // FETCH's pc/IR strobes wait on memory; other states are unconditional
    assign fetch_qual = (state_q != STATE_WIDTH'(S_FETCH)) | memory_ready;

    assign pc_write          = ~reset & ((cw.pc_update & fetch_qual) | (cw.branch & zero));
    assign instruction_write = ~reset & cw.instruction_write & fetch_qual;
    assign memory_write      = ~reset & cw.memory_write;
    assign reg_write         = ~reset & cw.reg_write;
    assign address_select    = cw.address_select;
    assign result_select     = cw.result_select;
    assign ALU_src_a         = cw.src_a;
    assign ALU_src_b         = cw.src_b;
    assign ALU_op            = cw.alu_op;
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
    assign illegal_instruction = ~reset & cw.illegal;
`else
    assign illegal_instruction = 1'b0;
`endif

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter STATE_WIDTH, default 4, meaning the width of the state register; legal values are 4 or more.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-004 The block SHALL have port opcode, input, 7 bits: the opcode of the instruction register (lw 0000011, sw 0100011, R 0110011, beq 1100011, I-ALU 0010011, jal 1101111, lui 0110111).
REQ-005 The block SHALL have port zero, input, 1 bit: the ALU zero flag.
REQ-006 The block SHALL have port memory_ready, input, 1 bit: the memory access completes in the current cycle.
REQ-007 The block SHALL have outputs pc_write (1), address_select (1), memory_write (1), instruction_write (1) and reg_write (1).
REQ-008 The block SHALL have outputs result_select (2), ALU_src_a (2), ALU_src_b (2) and ALU_op (2).
REQ-009 The block SHALL have output illegal_instruction (1) when TRAP is compiled in; otherwise it is tied to 0.

Function
REQ-010 The block SHALL be a Moore FSM; outputs depend on state only, except the pc_write and write-strobe gating in REQ-012.
REQ-011 The block SHALL use these encodings: ALU_src_a 00 PC, 01 old_PC, 10 rd1, 11 zero; ALU_src_b 00 rd2, 01 imm, 10 const 4; result_select 00 ALU_out, 01 read data, 10 ALU_result; ALU_op 00 add, 01 sub, 10 funct.
REQ-012 The block SHALL drive pc_write = pc_update | (branch & zero), where pc_update in FETCH is qualified by memory_ready.
REQ-013 The block SHALL implement FETCH(0): address_select 0, src_a 00, src_b 10, ALU_op 00, result_select 10; instruction_write and pc_update only when memory_ready. It stays in FETCH while memory_ready=0, else goes to DECODE.
REQ-014 The block SHALL implement DECODE(1): src_a 01, src_b 01, ALU_op 00 (branch/jump target). Transitions: lw/sw to MEMADR, R to EXECUTER, I-ALU to EXECUTEI, beq to BEQ, jal to JAL, lui to LUI, other opcodes per REQ-024.
REQ-015 The block SHALL implement MEMADR(2): src_a 10, src_b 01, ALU_op 00. Transitions: lw to MEMREAD, sw to MEMWRITE.
REQ-016 The block SHALL implement MEMREAD(3): address_select 1, result_select 00; it holds until memory_ready, then goes to MEMWB.
REQ-017 The block SHALL implement MEMWB(4): result_select 01, reg_write 1, then go to FETCH.
REQ-018 The block SHALL implement MEMWRITE(5): address_select 1, result_select 00, memory_write 1 held; it holds until memory_ready, then goes to FETCH.
REQ-019 The block SHALL implement EXECUTER(6): src_a 10, src_b 00, ALU_op 10, then go to ALUWB. It SHALL implement EXECUTEI(7): src_a 10, src_b 01, ALU_op 10, then go to ALUWB.
REQ-020 The block SHALL implement ALUWB(8): result_select 00, reg_write 1, then go to FETCH.
REQ-021 The block SHALL implement BEQ(9): src_a 10, src_b 00, ALU_op 01, result_select 00, branch 1, then go to FETCH.
REQ-022 The block SHALL implement JAL(10): src_a 01, src_b 10, ALU_op 00, result_select 00, pc_update 1, then go to ALUWB. It SHALL implement LUI(11): src_a 11, src_b 01, ALU_op 00, then go to ALUWB.
REQ-023 In every state, any enable not listed for that state SHALL be 0 and any select not listed SHALL be 00.
REQ-024 An undefined opcode in DECODE SHALL go to FETCH (no architectural effect) unless TRAP is enabled.
REQ-025 An unreachable state encoding SHALL go to FETCH on the next clock.
REQ-026 Opcode SHALL be sampled only in DECODE and MEMADR.

Reset
REQ-027 When reset=1 at a clock edge, the state SHALL become FETCH, overriding any pending memory wait or transition.
REQ-028 While in reset, all enables SHALL be 0 and illegal_instruction SHALL be 0.
REQ-029 Reset applied mid-MEMWRITE SHALL deassert memory_write in the cycle after the reset edge.

Configuration
REQ-030 When MULTICYCLE_CONTROLLER_TRAP_EN is defined, an undefined opcode in DECODE SHALL go to TRAP(12): all enables 0, illegal_instruction 1, held until reset.
REQ-031 When MULTICYCLE_CONTROLLER_TRAP_EN is undefined, there SHALL be no TRAP state and REQ-024 applies.

Structure
REQ-032 A shared package/header SHALL hold the opcode constants, state encodings, and select/ALU_op encodings.
REQ-033 The block SHALL contain one sub-module, controller_output_decoder: state to control word, combinational.

Verification
REQ-034 Reset, then memory_ready=1, opcode 0000011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; result_select=01 in state 4.
REQ-035 sw with memory_ready low for 3 cycles in MEMWRITE -> memory_write=1 for 4 cycles, then FETCH; reg_write never 1.
REQ-036 beq with zero=1 -> pc_write=1 in BEQ; beq with zero=0 -> pc_write=0 in BEQ; both return to FETCH after 3 cycles.
REQ-037 jal -> 0,1,10,8,0; pc_write=1 in FETCH and JAL; reg_write=1 in ALUWB. lui -> src_a=11 in LUI.
REQ-038 opcode 1111111 -> with TRAP_EN, illegal_instruction=1 from cycle 3 and persists; without it, back in FETCH at cycle 3.
REQ-039 reset asserted during MEMREAD wait -> FETCH next cycle, all enables 0.
